// File: rtl/ether_frame_tx.sv
// RMII Ethernet frame transmitter: preamble, SFD, header, streamed payload, zero pad,
// CRC-32 FCS and inter-frame gap, emitted as one 2-bit dibit per clock, LSB dibit first.
// The state registers always describe the dibit currently on axiod.
module ether_frame_tx #(
    parameter logic [47:0] DST_MAC       = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC       = 48'h6969_5A06_5491,
    parameter logic [15:0] ETHERTYPE     = 16'h88B5,
    parameter int unsigned PAYLOAD_BYTES = 46,
    parameter int unsigned IFG_CYCLES    = 48
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       trigger_in,
    input  logic       payload_axiiv,
    input  logic [7:0] payload_axiid,
    output logic       payload_axiir,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       busy_out,
    output logic       frame_done_out,
    output logic       underrun_out
);

    localparam int unsigned DataBytes = (PAYLOAD_BYTES > 46) ? PAYLOAD_BYTES : 46;
    localparam int unsigned PadBytes  = DataBytes - PAYLOAD_BYTES;
    localparam int unsigned CntMax    = (DataBytes > IFG_CYCLES) ? DataBytes : IFG_CYCLES;
    localparam int unsigned CntW      = $clog2(CntMax + 1);

    localparam logic [111:0]    Header  = {DST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [CntW-1:0] LastPre = CntW'(6);
    localparam logic [CntW-1:0] LastHdr = CntW'(13);
    localparam logic [CntW-1:0] LastPay = CntW'(PAYLOAD_BYTES - 1);
    localparam logic [CntW-1:0] LastPad = CntW'(PadBytes - 1);
    localparam logic [CntW-1:0] LastFcs = CntW'(3);
    localparam logic [CntW-1:0] LastIfg = CntW'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StPreamble, StSfd, StHeader, StPayload, StPad, StFcs, StIfg
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      dib_q, dib_d;
    logic [31:0]     sh_q, sh_d;     // bits still to send, LSB dibit on the wire
    logic [31:0]     crc_q, crc_d;
    logic            und_q, und_d;

    logic [31:0] crc_upd;
    logic [7:0]  pay_byte;
    logic        byte_last;

    // Header byte i, MS byte of each field first.
    function automatic logic [7:0] hdr_byte(input logic [CntW-1:0] idx);
        logic [111:0] tmp;
        tmp = Header << (8 * idx);
        return tmp[111:104];
    endfunction

    // Reflected CRC-32 advanced by one dibit, bit 0 first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 2; k++) begin
            if (r[0] ^ d[k]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign crc_upd   = crc_dibit(crc_q, sh_q[1:0]);
    assign pay_byte  = payload_axiiv ? payload_axiid : 8'h00;
    assign byte_last = (dib_q == 2'd3);

    // Next-state: byte sequencing, CRC accumulation and payload fetch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dib_d   = dib_q + 2'd1;
        sh_d    = {2'b00, sh_q[31:2]};
        crc_d   = crc_q;
        und_d   = und_q;

        if (state_q == StHeader || state_q == StPayload || state_q == StPad) begin
            crc_d = crc_upd;
        end

        unique case (state_q)
            StIdle: begin
                dib_d = 2'd0;
                sh_d  = 32'h0;
                if (trigger_in) begin
                    state_d = StPreamble;
                    cnt_d   = '0;
                    sh_d    = 32'h55;
                    crc_d   = 32'hFFFF_FFFF;
                    und_d   = 1'b0;
                end
            end
            StPreamble: begin
                if (byte_last) begin
                    if (cnt_q == LastPre) begin
                        state_d = StSfd;
                        sh_d    = 32'hD5;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                        sh_d  = 32'h55;
                    end
                end
            end
            StSfd: begin
                crc_d = 32'hFFFF_FFFF;
                if (byte_last) begin
                    state_d = StHeader;
                    cnt_d   = '0;
                    sh_d    = {24'h0, hdr_byte('0)};
                end
            end
            StHeader: begin
                if (byte_last) begin
                    if (cnt_q == LastHdr) begin
                        state_d = StPayload;
                        cnt_d   = '0;
                        sh_d    = {24'h0, pay_byte};
                        und_d   = und_q | ~payload_axiiv;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                        sh_d  = {24'h0, hdr_byte(cnt_q + CntW'(1))};
                    end
                end
            end
            StPayload: begin
                if (byte_last) begin
                    cnt_d = '0;
                    if (cnt_q == LastPay) begin
                        if (PadBytes > 0) begin
                            state_d = StPad;
                            sh_d    = 32'h0;
                        end else begin
                            state_d = StFcs;
                            sh_d    = ~crc_upd;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                        sh_d  = {24'h0, pay_byte};
                        und_d = und_q | ~payload_axiiv;
                    end
                end
            end
            StPad: begin
                if (byte_last) begin
                    if (cnt_q == LastPad) begin
                        state_d = StFcs;
                        cnt_d   = '0;
                        sh_d    = ~crc_upd;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                        sh_d  = 32'h0;
                    end
                end
            end
            StFcs: begin
                // The full 32-bit FCS was loaded on entry; just keep shifting.
                if (byte_last) begin
                    if (cnt_q == LastFcs) begin
                        state_d = StIfg;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StIfg: begin
                dib_d = 2'd0;
                if (cnt_q == LastIfg) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dib_q   <= 2'd0;
            sh_q    <= 32'h0;
            crc_q   <= 32'hFFFF_FFFF;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dib_q   <= dib_d;
            sh_q    <= sh_d;
            crc_q   <= crc_d;
            und_q   <= und_d;
        end
    end

    // Outputs decoded directly from the state registers.
    always_comb begin
        axiov          = (state_q != StIdle) && (state_q != StIfg);
        axiod          = axiov ? sh_q[1:0] : 2'b00;
        busy_out       = (state_q != StIdle);
        frame_done_out = (state_q == StIfg) && (cnt_q == LastIfg);
        underrun_out   = und_q;
        payload_axiir  = byte_last &&
                         (((state_q == StHeader) && (cnt_q == LastHdr)) ||
                          ((state_q == StPayload) && (cnt_q != LastPay)));
    end

endmodule

// File: tb/tb_ether_frame_tx.sv
// Bench for ether_frame_tx: a default instance (46 B payload) and a 10 B instance run in
// lockstep. Expected dibits are queued when a frame is triggered; a negedge monitor pops
// and compares them and checks frame length, CRC residue, gap length and done pulse.
module tb_ether_frame_tx;

    localparam int NPay0 = 46;
    localparam int NPay1 = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [7:0] d0 = 8'h0, d1 = 8'h0;
    logic       r0, r1, ov0, ov1, b0, b1, dn0, dn1, u0, u1;
    logic [1:0] od0, od1;

    int nchk = 0;
    int nerr = 0;

    logic [1:0]  exp0[$];
    logic [1:0]  exp1[$];
    int          slot[2] = '{0, 0};
    bit          pend[2] = '{0, 0};
    bit          clr[2]  = '{0, 0};
    bit          drop = 1'b0;
    bit          ign  = 1'b0;
    int          len[2]  = '{0, 0};
    int          blen[2] = '{0, 0};
    int          dcnt[2] = '{0, 0};
    bit          pv[2]   = '{0, 0};
    bit          pb[2]   = '{0, 0};
    bit          pdn[2]  = '{0, 0};
    logic [31:0] res[2];

    always #10 clk = ~clk;

    ether_frame_tx #(.PAYLOAD_BYTES(NPay0)) dut0 (
        .clk_in(clk), .rst_in(rst), .trigger_in(trig),
        .payload_axiiv(v0), .payload_axiid(d0), .payload_axiir(r0),
        .axiov(ov0), .axiod(od0), .busy_out(b0), .frame_done_out(dn0), .underrun_out(u0)
    );

    ether_frame_tx #(.PAYLOAD_BYTES(NPay1)) dut1 (
        .clk_in(clk), .rst_in(rst), .trigger_in(trig),
        .payload_axiiv(v1), .payload_axiid(d1), .payload_axiir(r1),
        .axiov(ov1), .axiod(od1), .busy_out(b1), .frame_done_out(dn1), .underrun_out(u1)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] crc_bits(logic [31:0] c, logic [7:0] d, int n);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < n; k++) begin
            if (r[0] ^ d[k]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Builds the whole expected frame byte-wise and queues it as dibits.
    function automatic void push_frame(int idx, int npay);
        logic [7:0]  b[$];
        logic [7:0]  hdr[14];
        logic [7:0]  x;
        logic [31:0] c;
        hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h69, 8'h69, 8'h5A, 8'h06, 8'h54, 8'h91, 8'h88, 8'hB5};
        for (int i = 0; i < 7; i++) b.push_back(8'h55);
        b.push_back(8'hD5);
        for (int i = 0; i < 14; i++) b.push_back(hdr[i]);
        for (int k = 0; k < npay; k++) begin
            x = (drop && k == 3) ? 8'h00 : k[7:0];
            b.push_back(x);
        end
        for (int k = npay; k < 46; k++) b.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < b.size(); i++) c = crc_bits(c, b[i], 8);
        c = ~c;
        for (int i = 0; i < 4; i++) b.push_back(c[8*i +: 8]);
        foreach (b[i]) begin
            for (int j = 0; j < 4; j++) begin
                if (idx == 0) exp0.push_back(b[i][2*j +: 2]);
                else          exp1.push_back(b[i][2*j +: 2]);
            end
        end
    endfunction

    function automatic void mon(int idx, logic v, logic [1:0] d, logic busy, logic done);
        logic [1:0] e;
        int npay;
        npay = (idx == 0) ? NPay0 : NPay1;
        if (ign) return;
        if (v) begin
            if (idx == 0) e = (exp0.size() != 0) ? exp0.pop_front() : 2'bxx;
            else          e = (exp1.size() != 0) ? exp1.pop_front() : 2'bxx;
            check($sformatf("dibit%0d[%0d]", idx, len[idx]), {30'h0, d}, {30'h0, e});
            if (len[idx] == 32) res[idx] = 32'hFFFF_FFFF;
            if (len[idx] >= 32) res[idx] = crc_bits(res[idx], {6'h0, d}, 2);
            len[idx]++;
        end else begin
            if (busy) check($sformatf("ifg_dibit%0d", idx), {30'h0, d}, 32'h0);
            if (pv[idx]) begin
                check($sformatf("axiov_len%0d", idx), len[idx], 288);
                check($sformatf("crc_residue%0d", idx), res[idx], 32'hDEBB_20E3);
                check($sformatf("axiir_pulses%0d", idx), slot[idx], npay);
                check($sformatf("queue_left%0d", idx),
                      (idx == 0) ? exp0.size() : exp1.size(), 0);
                len[idx] = 0;
            end
        end
        if (busy) blen[idx]++;
        if (done) begin
            dcnt[idx]++;
            check($sformatf("done_while_tx%0d", idx), {31'h0, v}, 32'h0);
        end
        if (!busy && pb[idx]) begin
            check($sformatf("busy_len%0d", idx), blen[idx], 336);
            check($sformatf("done_pulses%0d", idx), dcnt[idx], 1);
            check($sformatf("done_last_cycle%0d", idx), {31'h0, pdn[idx]}, 32'h1);
            blen[idx] = 0;
            dcnt[idx] = 0;
        end
        pv[idx]  = v;
        pb[idx]  = busy;
        pdn[idx] = done;
    endfunction

    // Payload slot bookkeeping: one slot per axiir pulse, data = slot index.
    function automatic void drv(int idx, logic ir);
        if (clr[idx]) begin
            slot[idx] = 0;
            pend[idx] = 1'b0;
            clr[idx]  = 1'b0;
        end else if (pend[idx]) begin
            slot[idx]++;
        end
        pend[idx] = ir;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            mon(0, ov0, od0, b0, dn0);
            mon(1, ov1, od1, b1, dn1);
            drv(0, r0);
            drv(1, r1);
            d0 = 8'(slot[0]);
            v0 = !(drop && slot[0] == 3);
            d1 = 8'(slot[1]);
            v1 = !(drop && slot[1] == 3);
        end
    end

    task automatic start_frame();
        push_frame(0, NPay0);
        push_frame(1, NPay1);
        clr[0] = 1'b1;
        clr[1] = 1'b1;
        trig = 1'b1;
        @(posedge clk);
        #1;
        trig = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (b0 && n < budget);
        check("frame_end_in_budget", {31'h0, b0}, 32'h0);
    endtask

    task automatic check_quiet(string tag);
        check({tag, "_axiov0"}, {31'h0, ov0}, 32'h0);
        check({tag, "_axiod0"}, {30'h0, od0}, 32'h0);
        check({tag, "_axiir0"}, {31'h0, r0}, 32'h0);
        check({tag, "_busy0"}, {31'h0, b0}, 32'h0);
        check({tag, "_done0"}, {31'h0, dn0}, 32'h0);
        check({tag, "_axiov1"}, {31'h0, ov1}, 32'h0);
        check({tag, "_busy1"}, {31'h0, b1}, 32'h0);
        check({tag, "_axiir1"}, {31'h0, r1}, 32'h0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        check("reset_underrun0", {31'h0, u0}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Plain frame on both instances.
        start_frame();
        wait_idle(1000);
        check("no_underrun0", {31'h0, u0}, 32'h0);
        check("no_underrun1", {31'h0, u1}, 32'h0);

        // Payload byte 3 missing: sent as zero, underrun sticks.
        drop = 1'b1;
        start_frame();
        wait_idle(1000);
        drop = 1'b0;
        check("underrun_set0", {31'h0, u0}, 32'h1);
        check("underrun_set1", {31'h0, u1}, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        check("underrun_sticky0", {31'h0, u0}, 32'h1);

        // Next trigger clears underrun; mid-frame and done-cycle triggers are ignored.
        start_frame();
        check("underrun_clear0", {31'h0, u0}, 32'h0);
        check("underrun_clear1", {31'h0, u1}, 32'h0);
        repeat (50) @(posedge clk);
        #1;
        trig = 1'b1;
        @(posedge clk);
        #1;
        trig = 1'b0;
        n = 0;
        while (!dn0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", {31'h0, dn0}, 32'h1);
        trig = 1'b1;
        @(posedge clk);
        #1;
        trig = 1'b0;
        check("busy_fell", {31'h0, b0}, 32'h0);
        check("done_trig_ignored", {31'h0, ov0}, 32'h0);

        // Trigger in the first idle cycle starts a frame on the next cycle.
        start_frame();
        check("restart_axiov", {31'h0, ov0}, 32'h1);
        check("restart_busy", {31'h0, b0}, 32'h1);
        check("restart_first_dibit", {30'h0, od0}, 32'h1);

        // Reset 100 cycles into the frame.
        repeat (99) @(posedge clk);
        #1;
        ign = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_quiet("midreset");
        rst = 1'b0;
        exp0.delete();
        exp1.delete();
        for (int i = 0; i < 2; i++) begin
            len[i]  = 0;
            blen[i] = 0;
            dcnt[i] = 0;
            pv[i]   = 1'b0;
            pb[i]   = 1'b0;
            pdn[i]  = 1'b0;
        end
        ign = 1'b0;
        @(posedge clk);
        #1;

        // Full frame after the aborted one.
        start_frame();
        wait_idle(1000);
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
